// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MIPS writeback arbiter and its late-result FIFO.
package mips_wb_pkg;

  localparam int REGNUM_W = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // One queued writeback: destination, value, and whether it may still be committed.
  typedef struct packed {
    logic [REGNUM_W-1:0] regnum;
    logic [DATA_W-1:0]   data;
    logic                live;
  } wb_entry_t;

  // One-hot decode of a register number into the register-file bit mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REGNUM_W-1:0] regnum);
    return NUM_REGS'(1) << regnum;
  endfunction

endpackage

// File: rtl/wb_late_fifo.sv
// Late-result FIFO: circular buffer of pending writebacks with squash-by-register
// and a per-register pending mask derived from the live entries.
module wb_late_fifo
  import mips_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_push,
  input  logic [REGNUM_W-1:0] i_push_regnum,
  input  logic [DATA_W-1:0]   i_push_data,
  input  logic                i_pop,
  input  logic                i_squash_valid,
  input  logic [REGNUM_W-1:0] i_squash_regnum,
  output wb_entry_t           o_head,
  output logic                o_full,
  output logic                o_empty,
  output logic [CNT_W-1:0]    o_count,
  output logic [NUM_REGS-1:0] o_pending
);

  logic [REGNUM_W-1:0] r_regnum [DEPTH];
  logic [DATA_W-1:0]   r_data   [DEPTH];
  logic [DEPTH-1:0]    r_live;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [DEPTH-1:0]    w_live_next;
  logic                w_push_live;

  // A result pushed in the same cycle as an ALU write to its register is already stale.
  assign w_push_live = ~(i_squash_valid && (i_squash_regnum == i_push_regnum));

  // Next live vector: retire the popped slot, squash matches, mark the new tail.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_live_next = r_live;
    if (i_pop) w_live_next[r_head] = 1'b0;
    if (i_squash_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_regnum[i] == i_squash_regnum) w_live_next[i] = 1'b0;
      end
    end
    if (i_push) w_live_next[r_tail] = w_push_live;
  end

  // Entry payload storage, written at the tail on push.
  always_ff @(posedge clock) begin
    // NOTE: payload arrays carry no reset; a slot is only trusted while its live bit is set,
    // and live bits are reset, so clearing the data would cost logic for nothing.
    if (i_push) begin
      r_regnum[r_tail] <= i_push_regnum;
      r_data[r_tail]   <= i_push_data;
    end
  end

  // Pointers, occupancy and live bits.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_live  <= '0;
    end else begin
      r_live <= w_live_next;
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pending mask: OR of the one-hot destination of every live entry.
  always_comb begin
    o_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) o_pending = o_pending | reg_onehot(r_regnum[i]);
    end
  end

  assign o_head  = '{regnum: r_regnum[r_head], data: r_data[r_head], live: r_live[r_head]};
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mips_wb_arbiter.sv
// Writeback arbiter in front of the register-file write port: ALU results win,
// late results queue in a FIFO and drain when the ALU is idle.
module mips_wb_arbiter
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alu_valid,
  input  logic [REGNUM_W-1:0]     alu_regnum,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    late_valid,
  output logic                    late_ready,
  input  logic [REGNUM_W-1:0]     late_regnum,
  input  logic [DATA_W-1:0]       late_data,
  output logic [REGNUM_W-1:0]     wr_regnum,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    writeenable,
  output logic [NUM_REGS-1:0]     pending,
  output logic [$clog2(DEPTH):0]  count
);

  logic                w_alu_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  wb_entry_t           w_head;
  logic [REGNUM_W-1:0] r_wr_regnum;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_writeenable;

  // Arbitration: a real ALU write blocks the pop; r0 targets never write or enqueue.
  always_comb begin
    w_alu_issue = alu_valid && (alu_regnum != '0) && !reset;
    w_push      = late_valid && late_ready && (late_regnum != '0);
    w_pop       = !w_alu_issue && !w_empty && !reset;
  end

  assign late_ready = !w_full && !reset;

  wb_late_fifo #(.DEPTH(DEPTH)) u_late_fifo (
    .clock           (clock),
    .reset           (reset),
    .i_push          (w_push),
    .i_push_regnum   (late_regnum),
    .i_push_data     (late_data),
    .i_pop           (w_pop),
    .i_squash_valid  (w_alu_issue),
    .i_squash_regnum (alu_regnum),
    .o_head          (w_head),
    .o_full          (w_full),
    .o_empty         (w_empty),
    .o_count         (count),
    .o_pending       (pending)
  );

  // Registered regfile write port; a dead head pops without writing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_writeenable <= 1'b0;
      r_wr_regnum   <= '0;
      r_wr_data     <= '0;
    end else if (w_alu_issue) begin
      r_writeenable <= 1'b1;
      r_wr_regnum   <= alu_regnum;
      r_wr_data     <= alu_data;
    end else if (w_pop && w_head.live) begin
      r_writeenable <= 1'b1;
      r_wr_regnum   <= w_head.regnum;
      r_wr_data     <= w_head.data;
    end else begin
      r_writeenable <= 1'b0;
      r_wr_regnum   <= '0;
      r_wr_data     <= '0;
    end
  end

  assign writeenable = r_writeenable;
  assign wr_regnum   = r_wr_regnum;
  assign wr_data     = r_wr_data;

endmodule

// File: tb/tb_mips_wb_arbiter.sv
// Self-checking bench for mips_wb_arbiter: a queue-based reference model predicts each
// cycle's write into a scoreboard, which is popped when the DUT presents the write.
module tb_mips_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_regnum = '0;
  logic [31:0] alu_data = '0;
  logic        late_valid = 1'b0;
  logic        late_ready;
  logic [4:0]  late_regnum = '0;
  logic [31:0] late_data = '0;
  logic [4:0]  wr_regnum;
  logic [31:0] wr_data;
  logic        writeenable;
  logic [31:0] pending;
  logic [2:0]  count;

  always #5 clock = ~clock;

  mips_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_regnum  (alu_regnum),
    .alu_data    (alu_data),
    .late_valid  (late_valid),
    .late_ready  (late_ready),
    .late_regnum (late_regnum),
    .late_data   (late_data),
    .wr_regnum   (wr_regnum),
    .wr_data     (wr_data),
    .writeenable (writeenable),
    .pending     (pending),
    .count       (count)
  );

  typedef struct {
    logic [4:0]  regnum;
    logic [31:0] data;
    bit          live;
  } m_entry_t;

  typedef struct {
    logic [4:0]  regnum;
    logic [31:0] data;
  } wr_t;

  m_entry_t    q[$];
  wr_t         sb[$];
  logic [31:0] shadow [32];
  bit          m_acc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (q[i]) if (q[i].live) p[q[i].regnum] = 1'b1;
    return p;
  endfunction

  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld);
    alu_valid   = av;
    alu_regnum  = ar;
    alu_data    = ad;
    late_valid  = lv;
    late_regnum = lr;
    late_data   = ld;
  endtask

  // Advance one clock: predict the edge from current inputs, then check the DUT after it.
  task automatic tick();
    bit       m_ready;
    bit       alu_q;
    bit       exp_we;
    m_entry_t h;
    wr_t      w;
    m_ready = (q.size() != DEPTH) && !reset;
    m_acc   = late_valid && m_ready;
    exp_we  = 1'b0;
    if (reset) begin
      q.delete();
    end else begin
      alu_q = alu_valid && (alu_regnum != 0);
      if (alu_q) begin
        exp_we = 1'b1;
        sb.push_back('{alu_regnum, alu_data});
      end else if (q.size() > 0) begin
        h = q.pop_front();
        if (h.live) begin
          exp_we = 1'b1;
          sb.push_back('{h.regnum, h.data});
        end
      end
      if (alu_q) begin
        for (int i = 0; i < q.size(); i++) if (q[i].regnum == alu_regnum) q[i].live = 1'b0;
      end
      if (m_acc && late_regnum != 0)
        q.push_back('{late_regnum, late_data, !(alu_q && late_regnum == alu_regnum)});
    end
    @(posedge clock);
    #1;
    check("we", writeenable, exp_we);
    if (exp_we && sb.size() > 0) begin
      w = sb.pop_front();
      if (writeenable) begin
        check("wr_regnum", wr_regnum, w.regnum);
        check("wr_data", wr_data, w.data);
      end
    end
    check("count", count, q.size());
    check("pending", pending, model_pending());
    check("late_ready", late_ready, (q.size() != DEPTH) && !reset);
    if (writeenable === 1'b1) shadow[wr_regnum] = wr_data;
  endtask

  initial begin
    logic [4:0] bp_exp [5];
    int         bp_k;
    bp_exp = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd7};
    foreach (shadow[i]) shadow[i] = '0;

    // Reset held two cycles with a late offer present.
    reset = 1'b1;
    drive(0, 0, 0, 1, 5'd9, 32'h99);
    #1;
    check("rst_ready_during", late_ready, 1'b0);
    tick();
    tick();
    check("rst_we", writeenable, 1'b0);
    check("rst_count", count, 3'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_ready_after", late_ready, 1'b1);

    // ALU path.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    check("alu_regnum", wr_regnum, 5'd5);
    check("alu_data", wr_data, 32'hDEADBEEF);
    check("alu_we", writeenable, 1'b1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("alu_idle_we", writeenable, 1'b0);

    // Late path.
    drive(0, 0, 0, 1, 5'd8, 32'h11);
    tick();
    check("late_pending8", pending[8], 1'b1);
    check("late_count", count, 3'd1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("late_regnum", wr_regnum, 5'd8);
    check("late_data", wr_data, 32'h11);
    check("late_pending_clr", pending, 32'h0);

    // Backpressure: ALU busy while four late results fill the FIFO.
    drive(1, 5'd1, 32'h100, 1, 5'd2, 32'h200); tick();
    drive(1, 5'd1, 32'h101, 1, 5'd3, 32'h300); tick();
    drive(1, 5'd1, 32'h102, 1, 5'd4, 32'h400); tick();
    drive(1, 5'd1, 32'h103, 1, 5'd6, 32'h600); tick();
    check("bp_full_count", count, 3'd4);
    check("bp_full_ready", late_ready, 1'b0);
    drive(1, 5'd1, 32'h104, 1, 5'd7, 32'h700); tick();
    check("bp_held_count", count, 3'd4);
    drive(0, 0, 0, 1, 5'd7, 32'h700);
    bp_k = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_acc) late_valid = 1'b0;
      check($sformatf("bp_order_%0d", i), wr_regnum, bp_exp[i]);
      if (writeenable) bp_k++;
    end
    check("bp_write_cycles", bp_k, 5);

    // Squash: late r3 queued behind an ALU write, then a newer ALU write to r3.
    drive(1, 5'd1, 32'h111, 1, 5'd3, 32'hA); tick();
    drive(1, 5'd3, 32'hB, 0, 0, 0); tick();
    check("sq_pending3", pending[3], 1'b0);
    check("sq_alu_data", wr_data, 32'hB);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("sq_dead_we", writeenable, 1'b0);
    check("sq_r3_final", shadow[3], 32'hB);

    // r0 handling on both paths.
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0); tick();
    check("r0_alu_we", writeenable, 1'b0);
    drive(0, 0, 0, 1, 5'd0, 32'h55);
    #1;
    check("r0_late_ready", late_ready, 1'b1);
    tick();
    check("r0_late_count", count, 3'd0);
    drive(0, 0, 0, 0, 0, 0); tick();
    check("r0_late_we", writeenable, 1'b0);

    // Reset mid-drain loses queued writes.
    drive(1, 5'd1, 32'h1, 1, 5'd10, 32'hA0); tick();
    drive(1, 5'd1, 32'h2, 1, 5'd11, 32'hB0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    reset = 1'b1; tick();
    check("mid_rst_count", count, 3'd0);
    check("mid_rst_pending", pending, 32'h0);
    reset = 1'b0; tick();

    // Random traffic over a few registers to hit squash, r0 and full cases.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 5)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)), $urandom);
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2 * DEPTH; c++) tick();
    check("drain_count", count, 3'd0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
